// File: rtl/cr16_pkg.sv
// Shared CR16 writeback definitions.
// Holds the data/register widths, the address and word types, the queue entry
// record {live, addr, data}, and a one-hot helper for the pending scoreboard.
package cr16_pkg;

    localparam int WIDTH         = 16;
    localparam int REGISTER_BITS = 4;
    localparam int NUM_REGS      = 1 << REGISTER_BITS;

    typedef logic [REGISTER_BITS-1:0] reg_addr_t;
    typedef logic [WIDTH-1:0]         word_t;

    typedef struct packed {
        logic      live;
        reg_addr_t addr;
        word_t     data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input reg_addr_t addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/wb_queue.sv
// In-order circular buffer of ALU results awaiting the register file port.
// Ports:
//   clock, reset    rising-edge clock, synchronous active-low reset
//   push_i          enqueue push_entry_i at the tail (stored live)
//   push_entry_i    entry to enqueue
//   pop_i           drop the head entry (caller guarantees count_o > 0)
//   kill_i          mark every queued live entry whose addr == kill_addr_i killed
//   kill_addr_i     address to kill
//   head_o          current head entry
//   count_o         occupied entries, live or killed
//   live_mask_o     registered OR of one-hot(addr) over live entries
module wb_queue
    import cr16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_i,
    input  wb_entry_t               push_entry_i,
    input  logic                    pop_i,
    input  logic                    kill_i,
    input  reg_addr_t               kill_addr_i,
    output wb_entry_t               head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [NUM_REGS-1:0]     live_mask_o
);

    localparam int PTR_BITS   = $clog2(DEPTH);
    localparam int COUNT_BITS = PTR_BITS + 1;

    wb_entry_t               mem_q [DEPTH];
    wb_entry_t               mem_d [DEPTH];
    logic [PTR_BITS-1:0]     head_q, head_d;
    logic [PTR_BITS-1:0]     tail_q, tail_d;
    logic [COUNT_BITS-1:0]   count_q, count_d;
    logic [NUM_REGS-1:0]     live_mask_q, live_mask_d;

    always_comb begin
        mem_d       = mem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        live_mask_d = '0;

        // Kill only touches entries already queued; the entry pushed this
        // cycle is younger than the killing load and stays live.
        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].live && (mem_q[i].addr == kill_addr_i)) begin
                    mem_d[i].live = 1'b0;
                end
            end
        end

        // Clearing live on pop keeps vacant slots out of the scoreboard.
        if (pop_i) begin
            mem_d[head_q].live = 1'b0;
            head_d             = head_q + 1'b1;
        end

        if (push_i) begin
            mem_d[tail_q]      = push_entry_i;
            mem_d[tail_q].live = 1'b1;
            tail_d             = tail_q + 1'b1;
        end

        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        for (int i = 0; i < DEPTH; i++) begin
            if (mem_d[i].live) begin
                live_mask_d = live_mask_d | addr_onehot(mem_d[i].addr);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            live_mask_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            live_mask_q <= live_mask_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head_o      = mem_q[head_q];
    assign count_o     = count_q;
    assign live_mask_o = live_mask_q;

endmodule

// File: rtl/regfile_writeback_stage.sv
// CR16 writeback stage: owns the single register-file write port and merges
// load results (never stalled) with ALU results (valid/ready, queued on
// collision). Exports a pending-write scoreboard for decode.
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-low reset
//   alu_valid/alu_ready           ALU result handshake
//   alu_addr, alu_data            ALU destination and result
//   load_valid                    load result present, consumed this cycle
//   load_addr, load_data          load destination and result
//   rf_write_en/addr/data         registered register-file write port
//   pending                       bit n set while a live queued write targets rn
//   queue_count                   occupied queue entries, live or killed
module regfile_writeback_stage
    import cr16_pkg::*;
#(
    parameter int WIDTH         = cr16_pkg::WIDTH,
    parameter int REGISTER_BITS = cr16_pkg::REGISTER_BITS,
    parameter int DEPTH         = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [REGISTER_BITS-1:0]    alu_addr,
    input  logic [WIDTH-1:0]            alu_data,
    input  logic                        load_valid,
    input  logic [REGISTER_BITS-1:0]    load_addr,
    input  logic [WIDTH-1:0]            load_data,
    output logic                        rf_write_en,
    output logic [REGISTER_BITS-1:0]    rf_write_addr,
    output logic [WIDTH-1:0]            rf_write_data,
    output logic [(1<<REGISTER_BITS)-1:0] pending,
    output logic [$clog2(DEPTH):0]      queue_count
);

    localparam int COUNT_BITS = $clog2(DEPTH) + 1;
    localparam logic [COUNT_BITS-1:0] FULL_COUNT = COUNT_BITS'(DEPTH);

    wb_entry_t                   head_entry;
    wb_entry_t                   push_entry;
    logic [COUNT_BITS-1:0]       count;
    logic                        alu_xfer;
    logic                        load_sel;
    logic                        queue_empty;
    logic                        pop;
    logic                        head_write;
    logic                        bypass;
    logic                        push;

    logic                        rf_write_en_q, rf_write_en_d;
    logic [REGISTER_BITS-1:0]    rf_write_addr_q, rf_write_addr_d;
    logic [WIDTH-1:0]            rf_write_data_q, rf_write_data_d;

    // Ready depends only on reset and occupancy, never on the valids.
    assign alu_ready   = reset && (count < FULL_COUNT);
    assign alu_xfer    = alu_valid && alu_ready;
    assign load_sel    = load_valid && (load_addr != '0);
    assign queue_empty = (count == '0);

    assign pop        = !load_sel && !queue_empty;
    assign head_write = pop && head_entry.live;
    assign bypass     = !load_sel && queue_empty && alu_xfer && (alu_addr != '0);
    // An accepted ALU result waits whenever the port is taken or older work
    // is queued; r0 results are simply dropped.
    assign push       = alu_xfer && (alu_addr != '0) && (load_sel || !queue_empty);

    assign push_entry = '{live: 1'b1, addr: alu_addr, data: alu_data};

    wb_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .kill_i       (load_sel),
        .kill_addr_i  (load_addr),
        .head_o       (head_entry),
        .count_o      (count),
        .live_mask_o  (pending)
    );

    always_comb begin
        rf_write_en_d   = 1'b0;
        rf_write_addr_d = rf_write_addr_q;
        rf_write_data_d = rf_write_data_q;
        if (load_sel) begin
            rf_write_en_d   = 1'b1;
            rf_write_addr_d = load_addr;
            rf_write_data_d = load_data;
        end else if (head_write) begin
            rf_write_en_d   = 1'b1;
            rf_write_addr_d = head_entry.addr;
            rf_write_data_d = head_entry.data;
        end else if (bypass) begin
            rf_write_en_d   = 1'b1;
            rf_write_addr_d = alu_addr;
            rf_write_data_d = alu_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rf_write_en_q   <= 1'b0;
            rf_write_addr_q <= '0;
            rf_write_data_q <= '0;
        end else begin
            rf_write_en_q   <= rf_write_en_d;
            rf_write_addr_q <= rf_write_addr_d;
            rf_write_data_q <= rf_write_data_d;
        end
    end

    assign rf_write_en   = rf_write_en_q;
    assign rf_write_addr = rf_write_addr_q;
    assign rf_write_data = rf_write_data_q;
    assign queue_count   = count;

endmodule

// File: tb/tb_regfile_writeback_stage.sv
// Directed bench for regfile_writeback_stage with hand-computed expectations.
module tb_regfile_writeback_stage;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_addr;
    logic [15:0] alu_data;
    logic        load_valid;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic        rf_write_en;
    logic [3:0]  rf_write_addr;
    logic [15:0] rf_write_data;
    logic [15:0] pending;
    logic [2:0]  queue_count;

    int n_checks = 0;
    int n_errors = 0;

    regfile_writeback_stage #(
        .WIDTH(16),
        .REGISTER_BITS(4),
        .DEPTH(4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .load_valid    (load_valid),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .pending       (pending),
        .queue_count   (queue_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [3:0] la, input logic [15:0] ld,
                         input logic av, input logic [3:0] aa, input logic [15:0] ad);
        load_valid = lv;
        load_addr  = la;
        load_data  = ld;
        alu_valid  = av;
        alu_addr   = aa;
        alu_data   = ad;
    endtask

    task automatic expect_write(input string tag, input logic en, input logic [3:0] addr,
                                input logic [15:0] data);
        check({tag, ".en"}, rf_write_en, en);
        check({tag, ".addr"}, rf_write_addr, addr);
        check({tag, ".data"}, rf_write_data, data);
    endtask

    task automatic expect_queue(input string tag, input logic [15:0] pend, input logic [2:0] cnt);
        check({tag, ".pending"}, pending, pend);
        check({tag, ".count"}, queue_count, cnt);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // reset and idle
        step();
        step();
        check("rst.ready", alu_ready, 1'b0);
        expect_write("rst", 0, 0, 0);
        expect_queue("rst", 16'h0000, 3'd0);
        reset = 1'b1;
        #1;
        check("rst.ready_after", alu_ready, 1'b1);

        // bypass
        drive(0, 0, 0, 1, 4'd3, 16'h1234);
        step();
        drive(0, 0, 0, 0, 0, 0);
        expect_write("bypass", 1, 4'd3, 16'h1234);
        expect_queue("bypass", 16'h0000, 3'd0);
        step();
        expect_write("idle_hold", 0, 4'd3, 16'h1234);

        // collision
        drive(1, 4'd5, 16'hAAAA, 1, 4'd6, 16'h0001);
        step();
        drive(0, 0, 0, 0, 0, 0);
        expect_write("coll1", 1, 4'd5, 16'hAAAA);
        expect_queue("coll1", 16'h0040, 3'd1);
        step();
        expect_write("coll2", 1, 4'd6, 16'h0001);
        expect_queue("coll2", 16'h0000, 3'd0);

        // kill
        drive(1, 4'd2, 16'h2222, 1, 4'd7, 16'h0007);
        step();
        expect_write("kill_a", 1, 4'd2, 16'h2222);
        expect_queue("kill_a", 16'h0080, 3'd1);
        drive(1, 4'd7, 16'hBEEF, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        expect_write("kill_b", 1, 4'd7, 16'hBEEF);
        expect_queue("kill_b", 16'h0000, 3'd1);
        step();
        expect_write("kill_pop", 0, 4'd7, 16'hBEEF);
        expect_queue("kill_pop", 16'h0000, 3'd0);

        // full / backpressure: loads r8..r12, ALU source r1..r5
        begin
            logic [15:0] exp_pend [5];
            logic [2:0]  exp_cnt  [5];
            exp_pend[0] = 16'h0002; exp_cnt[0] = 3'd1;
            exp_pend[1] = 16'h0006; exp_cnt[1] = 3'd2;
            exp_pend[2] = 16'h000E; exp_cnt[2] = 3'd3;
            exp_pend[3] = 16'h001E; exp_cnt[3] = 3'd4;
            exp_pend[4] = 16'h001E; exp_cnt[4] = 3'd4;
            for (int i = 0; i < 5; i++) begin
                logic [3:0] src;
                src = (i < 4) ? 4'(i + 1) : 4'd5;
                drive(1, 4'(8 + i), 16'h8000 + 16'(i), 1, src, 16'h0100 + 16'(src));
                #1;
                check($sformatf("full%0d.ready", i), alu_ready, (i < 4) ? 1'b1 : 1'b0);
                step();
                expect_write($sformatf("full%0d", i), 1, 4'(8 + i), 16'h8000 + 16'(i));
                expect_queue($sformatf("full%0d", i), exp_pend[i], exp_cnt[i]);
            end
        end
        drive(0, 0, 0, 1, 4'd5, 16'h0105);
        step();
        expect_write("drain1", 1, 4'd1, 16'h0101);
        expect_queue("drain1", 16'h001C, 3'd3);
        check("drain1.ready", alu_ready, 1'b1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        expect_write("drain2", 1, 4'd2, 16'h0102);
        expect_queue("drain2", 16'h0038, 3'd3);
        step();
        expect_write("drain3", 1, 4'd3, 16'h0103);
        step();
        expect_write("drain4", 1, 4'd4, 16'h0104);
        step();
        expect_write("drain5", 1, 4'd5, 16'h0105);
        expect_queue("drain5", 16'h0000, 3'd0);

        // r0 handling
        drive(0, 0, 0, 1, 4'd0, 16'hFFFF);
        step();
        expect_write("r0_alu", 0, 4'd5, 16'h0105);
        expect_queue("r0_alu", 16'h0000, 3'd0);
        drive(1, 4'd0, 16'hDEAD, 1, 4'd9, 16'h0909);
        step();
        drive(0, 0, 0, 0, 0, 0);
        expect_write("r0_load", 1, 4'd9, 16'h0909);
        expect_queue("r0_load", 16'h0000, 3'd0);

        // reset mid-flight with three queued entries
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'(10 + i), 16'hA000 + 16'(i), 1, 4'(1 + i), 16'h0C00 + 16'(i));
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        expect_queue("pre_rst", 16'h000E, 3'd3);
        reset = 1'b0;
        step();
        check("mid_rst.ready", alu_ready, 1'b0);
        expect_write("mid_rst", 0, 0, 0);
        expect_queue("mid_rst", 16'h0000, 3'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_write($sformatf("post_rst%0d", i), 0, 0, 0);
        end
        expect_queue("post_rst", 16'h0000, 3'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
